// File: rtl/sum_parallel_pkg.sv
// sum_parallel_pkg: shared FSM encoding and datapath widths for the frame summer
package sum_parallel_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, RED1, RED2} state_e;
  localparam int FRAME_LEN_DEF = 128;
  localparam int LANE_W = 15;
  localparam int PAIR_W = 16;
  localparam int SUM_W = 17;
endpackage

// File: rtl/sum_rr_arb2.sv
// sum_rr_arb2: two-way round-robin arbiter; a tie goes to the requester not granted last
module sum_rr_arb2
  import sum_parallel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       winner,
  output logic [1:0] gnt,
  output logic       last
);
  logic last_q, last_d;
  // pick the winner and record it when the top commits a grant
  always_comb begin
    gnt = req == 2'b11 ? (last_q ? 2'b01 : 2'b10) : req;
    last_d = update ? winner : last_q;
  end
  // last-grant register resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else last_q <= last_d;
  end
  assign last = last_q;
endmodule

// File: rtl/sum_parallel_sched.sv
// sum_parallel_sched: arbitrated frame summer with four interleaved lanes and a two-level adder tree
module sum_parallel_sched
  import sum_parallel_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DW = 8
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [1:0]       req,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  input  logic             in_abort,
  output logic [1:0]       gnt,
  output logic             in_ready,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  output logic             sum_src,
  output logic             busy
);
  state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d, arb_gnt;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0][LANE_W-1:0] lane_q, lane_d;
  logic [PAIR_W-1:0] p01_q, p01_d, p23_q, p23_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic sum_valid_q, sum_valid_d, sum_src_q, sum_src_d;
  logic grant, last_grant_unused;

  sum_rr_arb2 u_arb (
    .clk   (CLK),
    .rst_n (RST_n),
    .req   (req),
    .update(grant),
    .winner(arb_gnt[1]),
    .gnt   (arb_gnt),
    .last  (last_grant_unused)
  );

  // next-state: grant, accumulate into lane cnt[1:0], then reduce pairs and total
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    lane_d = lane_q;
    p01_d = p01_q;
    p23_d = p23_q;
    sum_d = sum_q;
    sum_valid_d = 1'b0;
    sum_src_d = sum_src_q;
    grant = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        grant = 1'b1;
        gnt_d = arb_gnt;
        cnt_d = '0;
        lane_d = '0;
        state_d = ACCUM;
      end
      ACCUM: if (in_abort) begin
        gnt_d = '0;
        state_d = IDLE;
      end else if (in_valid) begin
        lane_d[cnt_q[1:0]] = lane_q[cnt_q[1:0]] + LANE_W'(in_data);
        cnt_d = cnt_q + 8'd1;
        state_d = cnt_q == 8'(FRAME_LEN - 1) ? RED1 : ACCUM;
      end
      RED1: begin
        p01_d = PAIR_W'(lane_q[0]) + PAIR_W'(lane_q[1]);
        p23_d = PAIR_W'(lane_q[2]) + PAIR_W'(lane_q[3]);
        state_d = RED2;
      end
      RED2: begin
        sum_d = SUM_W'(p01_q) + SUM_W'(p23_q);
        sum_src_d = gnt_q[1];
        sum_valid_d = 1'b1;
        gnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      cnt_q <= '0;
      lane_q <= '0;
      p01_q <= '0;
      p23_q <= '0;
      sum_q <= '0;
      sum_valid_q <= 1'b0;
      sum_src_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      lane_q <= lane_d;
      p01_q <= p01_d;
      p23_q <= p23_d;
      sum_q <= sum_d;
      sum_valid_q <= sum_valid_d;
      sum_src_q <= sum_src_d;
    end
  end

  assign gnt = gnt_q;
  assign in_ready = state_q == ACCUM;
  assign busy = state_q != IDLE;
  assign sum = sum_q;
  assign sum_valid = sum_valid_q;
  assign sum_src = sum_src_q;
endmodule

// File: doc/sum_parallel_sched.md
SUM_PARALLEL_SCHED -- requirements
Module: sum_parallel_sched

Interface
REQ-001 Parameter FRAME_LEN, default 128, means samples per frame; SHALL be a multiple of 4 in the range 4..252.
REQ-002 Parameter DW, default 8, means input sample width.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  2  per-requester frame request; bit i belongs to requester i.
REQ-006 in_data  input  DW  sample from the granted requester.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_abort  input  1  the granted requester abandons the current frame.
REQ-009 gnt  output  2  one-hot grant, held for the whole frame.
REQ-010 in_ready  output  1  high only in ACCUM; a sample is accepted when in_valid and in_ready are both high.
REQ-011 sum  output  17  frame total.
REQ-012 sum_valid  output  1  one-cycle pulse qualifying sum.
REQ-013 sum_src  output  1  index of the requester that owns sum.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM, RED1 and RED2.
REQ-016 IDLE, req != 0: the next edge SHALL set gnt one-hot, clear the sample counter and all four lane accumulators, and enter ACCUM.
REQ-017 Arbitration SHALL be round-robin: if exactly one req bit is set, that requester wins; if both are set, the requester not granted last wins.
REQ-018 ACCUM, accepted sample: the sample SHALL be added to lane cnt[1:0] (15-bit lane accumulator, zero-extended), and cnt SHALL increment.
REQ-019 ACCUM, in_valid low: the FSM SHALL stall with no state change; there is no timeout.
REQ-020 Accepting the sample at cnt == FRAME_LEN-1 SHALL move the FSM to RED1 at that edge.
REQ-021 RED1 SHALL register p01 = lane0 + lane1 and p23 = lane2 + lane3 (16 bits each), then move to RED2.
REQ-022 RED2 SHALL register sum = p01 + p23 (17 bits) and sum_src, assert sum_valid for exactly the following cycle, clear gnt, and return to IDLE.
REQ-023 Latency: sum_valid SHALL be high exactly 3 cycles after the cycle in which the last sample is accepted.
REQ-024 sum SHALL hold its value until the next sum_valid.
REQ-025 in_abort in ACCUM SHALL take priority over in_valid in the same cycle: return to IDLE at the next edge, clear gnt, discard the partial sums, and produce no sum_valid.
REQ-026 in_abort outside ACCUM SHALL be ignored.
REQ-027 An aborted frame SHALL still count as that requester's last grant for the round-robin rule.
REQ-028 req changes after a grant SHALL NOT affect the current frame.
REQ-029 A deasserted req during ACCUM SHALL NOT end the frame.
REQ-030 A new grant MAY be issued in the same cycle that sum_valid is high (back-to-back frames).
REQ-031 Arithmetic SHALL never overflow: FRAME_LEN*(2^DW-1) <= 2^17-1.

Reset
REQ-032 RST_n low at a clock edge SHALL force state IDLE, gnt = 0, in_ready = 0, busy = 0, sum = 0, sum_valid = 0 and sum_src = 0.
REQ-033 The same reset SHALL clear cnt, the lane accumulators, p01, p23, and set the last-grant register to 1, so that requester 0 wins the first tie.
REQ-034 Reset mid-frame SHALL discard the frame with no sum_valid.

Structure
REQ-035 Package sum_parallel_pkg SHALL hold the FSM state encoding, the FRAME_LEN default, and the lane (15), pair (16) and sum (17) widths.
REQ-036 The two-way round-robin arbiter SHALL be a sub-module named sum_rr_arb2 (inputs req, update, winner; outputs gnt and last-grant state).
REQ-037 The lane accumulators and adder tree SHALL remain in sum_parallel_sched.

Verification
REQ-038 Scenario 1: req = 01, 128 consecutive samples of value 1 -> sum = 128, sum_src = 0, sum_valid 3 cycles after the last sample.
REQ-039 Scenario 2: req = 11 held, two frames of 255s -> first frame gnt = 01 with sum = 32640; second frame gnt = 10, sum_src = 1.
REQ-040 Scenario 3: ramp 0..127 with in_valid toggling every other cycle -> sum = 8128, exactly 128 samples accepted, in_ready stays high throughout.
REQ-041 Scenario 4: in_abort together with in_valid at sample 50 -> no sum_valid, gnt = 0 next cycle, next tie granted to the other requester.
REQ-042 Scenario 5: RST_n low for one edge at sample 70 -> all outputs at reset values; a fresh frame of 2s then gives sum = 256.
REQ-043 Scenario 6: FRAME_LEN = 4, data 10, 20, 30, 40 -> lanes 10/20/30/40, p01 = 30, p23 = 70, sum = 100.
